// File: rtl/vx_commit_arbiter.sv
// Round-robin commit arbiter for one issue slot: several execution-unit commit
// streams share one registered, stallable output, with grants locked per packet.
module vx_commit_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 64,
    parameter int REQ_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       in_valid,
    input  logic [NUM_REQS*DATAW-1:0] in_data,
    input  logic [NUM_REQS-1:0]       in_sop,
    input  logic [NUM_REQS-1:0]       in_eop,
    output logic [NUM_REQS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [DATAW-1:0]          out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [REQ_W-1:0]          out_src,
    input  logic                      out_ready,
    output logic                      locked,
    output logic                      proto_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [REQ_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [REQ_W-1:0] lock_idx_q, lock_idx_d;
    logic             proto_err_q, proto_err_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sop_q, out_sop_d;
    logic             out_eop_q, out_eop_d;
    logic [REQ_W-1:0] out_src_q, out_src_d;
    logic [DATAW-1:0] out_data_q, out_data_d;

    logic             grant_valid;
    logic [REQ_W-1:0] grant_idx;
    logic [DATAW-1:0] sel_data;
    logic             sel_sop;
    logic             sel_eop;
    logic             adv;
    logic             accept;

    function automatic logic [REQ_W-1:0] nextIdx(input logic [REQ_W-1:0] idx);
        if (int'(idx) >= NUM_REQS - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // The scan runs from the farthest candidate down so the one nearest rr_ptr wins.
    always_comb begin
        int cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (state_q == LOCKED) begin
            grant_idx = lock_idx_q;
            for (int i = 0; i < NUM_REQS; i++) begin
                if (lock_idx_q == REQ_W'(i)) begin
                    grant_valid = in_valid[i];
                end
            end
        end else begin
            for (int k = NUM_REQS - 1; k >= 0; k--) begin
                cand = int'(rr_ptr_q) + k;
                if (cand >= NUM_REQS) begin
                    cand = cand - NUM_REQS;
                end
                for (int i = 0; i < NUM_REQS; i++) begin
                    if (cand == i && in_valid[i]) begin
                        grant_valid = 1'b1;
                        grant_idx   = REQ_W'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_sop  = 1'b0;
        sel_eop  = 1'b0;
        in_ready = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant_idx == REQ_W'(i)) begin
                sel_data    = in_data[i*DATAW +: DATAW];
                sel_sop     = in_sop[i];
                sel_eop     = in_eop[i];
                in_ready[i] = accept;
            end
        end
    end

    assign adv    = !out_valid_q || out_ready;
    assign accept = grant_valid && adv && reset;

    // Erroneous beats are still forwarded and still drive the normal transitions.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_idx_d  = lock_idx_q;
        proto_err_d = proto_err_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_src_d   = out_src_q;
        out_data_d  = out_data_q;

        if (adv) begin
            out_valid_d = accept;
        end

        if (accept) begin
            out_data_d = sel_data;
            out_sop_d  = sel_sop;
            out_eop_d  = sel_eop;
            out_src_d  = grant_idx;
            if (state_q == IDLE) begin
                if (!sel_sop) begin
                    proto_err_d = 1'b1;
                end
                if (sel_eop) begin
                    rr_ptr_d = nextIdx(grant_idx);
                end else begin
                    state_d    = LOCKED;
                    lock_idx_d = grant_idx;
                end
            end else begin
                if (sel_sop) begin
                    proto_err_d = 1'b1;
                end
                if (sel_eop) begin
                    state_d  = IDLE;
                    rr_ptr_d = nextIdx(lock_idx_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            lock_idx_q  <= '0;
            proto_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_idx_q  <= lock_idx_d;
            proto_err_q <= proto_err_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_src_q   <= out_src_d;
        end
    end

    // Payload is qualified by out_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        out_data_q <= out_data_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_src   = out_src_q;
    assign locked    = (state_q == LOCKED);
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Directed bench for vx_commit_arbiter: expected beats go into a queue that a
// negedge monitor drains whenever the output handshakes.
module tb_vx_commit_arbiter;

    localparam int NUM_REQS = 4;
    localparam int DATAW    = 64;
    localparam int REQ_W    = 2;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic             sop;
        logic             eop;
        logic [REQ_W-1:0] src;
    } beat_t;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQS-1:0]       in_valid;
    logic [NUM_REQS*DATAW-1:0] in_data;
    logic [NUM_REQS-1:0]       in_sop;
    logic [NUM_REQS-1:0]       in_eop;
    logic [NUM_REQS-1:0]       in_ready;
    logic                      out_valid;
    logic [DATAW-1:0]          out_data;
    logic                      out_sop;
    logic                      out_eop;
    logic [REQ_W-1:0]          out_src;
    logic                      out_ready;
    logic                      locked;
    logic                      proto_err;

    int    total = 0;
    int    bad   = 0;
    beat_t expQ[$];
    beat_t monExp;

    vx_commit_arbiter #(
        .NUM_REQS(NUM_REQS),
        .DATAW   (DATAW),
        .REQ_W   (REQ_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_sop   (in_sop),
        .in_eop   (in_eop),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .out_src  (out_src),
        .out_ready(out_ready),
        .locked   (locked),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic v, input logic s, input logic e, input logic [DATAW-1:0] d);
        in_valid[i]             = v;
        in_sop[i]               = s;
        in_eop[i]               = e;
        in_data[i*DATAW +: DATAW] = d;
    endtask

    task automatic clearAll();
        in_valid = '0;
        in_sop   = '0;
        in_eop   = '0;
    endtask

    task automatic expectBeat(input logic [DATAW-1:0] d, input logic s, input logic e, input logic [REQ_W-1:0] src);
        beat_t b;
        b.data = d;
        b.sop  = s;
        b.eop  = e;
        b.src  = src;
        expQ.push_back(b);
    endtask

    // Scoreboard side: every output handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpectedBeat: got src=%0d data=%h, required no beat", out_src, out_data);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("outData", out_data, monExp.data);
                checkOutput("outSop", 64'(out_sop), 64'(monExp.sop));
                checkOutput("outEop", 64'(out_eop), 64'(monExp.eop));
                checkOutput("outSrc", 64'(out_src), 64'(monExp.src));
            end
        end
    end

    initial begin
        reset     = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        in_valid  = '1;
        in_sop    = '1;
        in_eop    = '1;

        // Reset held with requesters valid: nothing may be accepted.
        applyStimulus(2);
        @(negedge clk);
        checkOutput("rstReady", 64'(in_ready), 64'h0);
        checkOutput("rstOutValid", 64'(out_valid), 64'h0);
        applyStimulus(1);
        clearAll();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("idleOutValid", 64'(out_valid), 64'h0);
            checkOutput("idleReady", 64'(in_ready), 64'h0);
            checkOutput("idleLocked", 64'(locked), 64'h0);
            checkOutput("idleProtoErr", 64'(proto_err), 64'h0);
            applyStimulus(1);
        end

        // Single-beat packets from every requester rotate 0,1,2,3 at full rate.
        for (int i = 0; i < NUM_REQS; i++) setReq(i, 1'b1, 1'b1, 1'b1, 64'h100 + 64'(i));
        for (int k = 0; k < 8; k++) expectBeat(64'h100 + 64'(k % 4), 1'b1, 1'b1, REQ_W'(k % 4));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("rrReady", 64'(in_ready), 64'(1 << (k % 4)));
            checkOutput("rrOutValid", 64'(out_valid), (k == 0) ? 64'h0 : 64'h1);
            applyStimulus(1);
        end
        clearAll();
        @(negedge clk);
        checkOutput("rrDrainReady", 64'(in_ready), 64'h0);
        applyStimulus(1);

        // 3-beat packet from 1 holds off the single beat waiting on 2.
        setReq(1, 1'b1, 1'b1, 1'b0, 64'hA0);
        setReq(2, 1'b1, 1'b1, 1'b1, 64'hB0);
        expectBeat(64'hA0, 1'b1, 1'b0, 2'd1);
        expectBeat(64'hA1, 1'b0, 1'b0, 2'd1);
        expectBeat(64'hA2, 1'b0, 1'b1, 2'd1);
        expectBeat(64'hB0, 1'b1, 1'b1, 2'd2);
        @(negedge clk);
        checkOutput("pktReady0", 64'(in_ready), 64'h2);
        checkOutput("pktLocked0", 64'(locked), 64'h0);
        applyStimulus(1);
        setReq(1, 1'b1, 1'b0, 1'b0, 64'hA1);
        @(negedge clk);
        checkOutput("pktReady1", 64'(in_ready), 64'h2);
        checkOutput("pktLocked1", 64'(locked), 64'h1);
        applyStimulus(1);
        setReq(1, 1'b1, 1'b0, 1'b1, 64'hA2);
        @(negedge clk);
        checkOutput("pktReady2", 64'(in_ready), 64'h2);
        checkOutput("pktLocked2", 64'(locked), 64'h1);
        applyStimulus(1);
        setReq(1, 1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("pktReady3", 64'(in_ready), 64'h4);
        checkOutput("pktLocked3", 64'(locked), 64'h0);
        applyStimulus(1);
        clearAll();
        applyStimulus(1);

        // Same packet with a 2-cycle bubble: requester 2 must stay blocked.
        setReq(1, 1'b1, 1'b1, 1'b0, 64'hC0);
        setReq(2, 1'b1, 1'b1, 1'b1, 64'hB1);
        expectBeat(64'hC0, 1'b1, 1'b0, 2'd1);
        expectBeat(64'hC1, 1'b0, 1'b0, 2'd1);
        expectBeat(64'hC2, 1'b0, 1'b1, 2'd1);
        expectBeat(64'hB1, 1'b1, 1'b1, 2'd2);
        @(negedge clk);
        checkOutput("gapReady0", 64'(in_ready), 64'h2);
        applyStimulus(1);
        setReq(1, 1'b0, 1'b0, 1'b0, 64'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("gapBubbleReady", 64'(in_ready), 64'h0);
            checkOutput("gapBubbleLocked", 64'(locked), 64'h1);
            applyStimulus(1);
        end
        setReq(1, 1'b1, 1'b0, 1'b0, 64'hC1);
        @(negedge clk);
        checkOutput("gapReady1", 64'(in_ready), 64'h2);
        applyStimulus(1);
        setReq(1, 1'b1, 1'b0, 1'b1, 64'hC2);
        @(negedge clk);
        checkOutput("gapReady2", 64'(in_ready), 64'h2);
        applyStimulus(1);
        setReq(1, 1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("gapReady3", 64'(in_ready), 64'h4);
        checkOutput("gapLocked3", 64'(locked), 64'h0);
        applyStimulus(1);
        clearAll();
        applyStimulus(1);

        // Output stall: 0x55 holds, nothing accepted, rr_ptr frozen at 1.
        setReq(0, 1'b1, 1'b1, 1'b1, 64'h55);
        expectBeat(64'h55, 1'b1, 1'b1, 2'd0);
        expectBeat(64'h77, 1'b1, 1'b1, 2'd2);
        expectBeat(64'h66, 1'b1, 1'b1, 2'd0);
        @(negedge clk);
        checkOutput("stallReady0", 64'(in_ready), 64'h1);
        applyStimulus(1);
        setReq(0, 1'b1, 1'b1, 1'b1, 64'h66);
        setReq(2, 1'b1, 1'b1, 1'b1, 64'h77);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("stallValid", 64'(out_valid), 64'h1);
            checkOutput("stallData", out_data, 64'h55);
            checkOutput("stallReady", 64'(in_ready), 64'h0);
            applyStimulus(1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("releaseReady", 64'(in_ready), 64'h4);
        applyStimulus(1);
        setReq(2, 1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("releaseNextReady", 64'(in_ready), 64'h1);
        applyStimulus(1);
        clearAll();
        @(negedge clk);
        applyStimulus(1);

        // sop=0 in IDLE: forwarded, error sticky until reset.
        setReq(3, 1'b1, 1'b0, 1'b1, 64'hE3);
        expectBeat(64'hE3, 1'b0, 1'b1, 2'd3);
        @(negedge clk);
        checkOutput("errReady", 64'(in_ready), 64'h8);
        checkOutput("errBefore", 64'(proto_err), 64'h0);
        applyStimulus(1);
        setReq(3, 1'b0, 1'b0, 1'b0, 64'h0);
        setReq(0, 1'b1, 1'b1, 1'b1, 64'h10);
        expectBeat(64'h10, 1'b1, 1'b1, 2'd0);
        @(negedge clk);
        checkOutput("errSet", 64'(proto_err), 64'h1);
        checkOutput("errNextReady", 64'(in_ready), 64'h1);
        applyStimulus(1);
        clearAll();
        @(negedge clk);
        checkOutput("errSticky", 64'(proto_err), 64'h1);
        applyStimulus(1);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("errCleared", 64'(proto_err), 64'h0);
        checkOutput("errRstValid", 64'(out_valid), 64'h0);
        applyStimulus(1);

        // sop=1 while locked also flags an error, packet still closes normally.
        setReq(1, 1'b1, 1'b1, 1'b0, 64'hD0);
        expectBeat(64'hD0, 1'b1, 1'b0, 2'd1);
        expectBeat(64'hD1, 1'b1, 1'b1, 2'd1);
        @(negedge clk);
        checkOutput("lockErrReady", 64'(in_ready), 64'h2);
        applyStimulus(1);
        setReq(1, 1'b1, 1'b1, 1'b1, 64'hD1);
        @(negedge clk);
        checkOutput("lockErrLocked", 64'(locked), 64'h1);
        checkOutput("lockErrBefore", 64'(proto_err), 64'h0);
        applyStimulus(1);
        clearAll();
        @(negedge clk);
        checkOutput("lockErrSet", 64'(proto_err), 64'h1);
        checkOutput("lockErrUnlocked", 64'(locked), 64'h0);
        applyStimulus(1);

        // Reset mid-packet on requester 2: packet abandoned, requester 0 wins first.
        setReq(2, 1'b1, 1'b1, 1'b0, 64'hF0);
        expectBeat(64'hF0, 1'b1, 1'b0, 2'd2);
        @(negedge clk);
        checkOutput("abandonReady", 64'(in_ready), 64'h4);
        applyStimulus(1);
        setReq(2, 1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("abandonLocked", 64'(locked), 64'h1);
        applyStimulus(1);
        reset = 1'b0;
        setReq(2, 1'b1, 1'b0, 1'b0, 64'hF1);
        setReq(0, 1'b1, 1'b1, 1'b1, 64'h20);
        @(negedge clk);
        checkOutput("abandonRstReady", 64'(in_ready), 64'h0);
        applyStimulus(1);
        reset = 1'b1;
        expectBeat(64'h20, 1'b1, 1'b1, 2'd0);
        @(negedge clk);
        checkOutput("abandonUnlocked", 64'(locked), 64'h0);
        checkOutput("abandonErr", 64'(proto_err), 64'h0);
        checkOutput("abandonValid", 64'(out_valid), 64'h0);
        checkOutput("abandonGrant", 64'(in_ready), 64'h1);
        applyStimulus(1);
        clearAll();
        applyStimulus(3);

        @(negedge clk);
        checkOutput("queueEmpty", 64'(expQ.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
